park_transform_engine: RTL

- Parametrised, bidirectional Park transform engine for the PMSM FOC datapath.
- Mode 0 (inverse Park) maps Ud/Uq to Ualpha/Ubeta ahead of SVPWM. Mode 1 (forward Park) maps Ialpha/Ibeta to Id/Iq after the Clarke stage.
- One signed multiplier is time-shared over 4 products; results are saturated.
- Operands are latched at accept, so inputs may change while the engine is busy.

---
 rtl/park_transform_engine_pkg.sv | 48 ++++
 rtl/park_transform_engine_if.sv | 27 ++
 rtl/park_transform_engine_mult_pipe.sv | 28 ++
 rtl/park_transform_engine.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/park_transform_engine_pkg.sv
// Shared types and helpers for the Park transform engine.
package park_pkg;

  localparam logic MODE_INV_PARK = 1'b0;
  localparam logic MODE_FWD_PARK = 1'b1;

  // Widest operand the saturation helper supports; sums are sign-extended to SUM_W.
  localparam int MAX_DW = 32;
  localparam int SUM_W  = 2 * MAX_DW + 1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } park_state_e;

  typedef struct packed {
    logic signed [MAX_DW-1:0] val;
    logic                     sat;
  } sat_res_t;

  // Floor shift by frac, then clamp to the signed dw-bit range.
  function automatic sat_res_t sat_shift(input logic signed [SUM_W-1:0] sum,
                                         input int frac, input int dw);
    logic signed [SUM_W-1:0] one_v;
    logic signed [SUM_W-1:0] max_v;
    logic signed [SUM_W-1:0] min_v;
    logic signed [SUM_W-1:0] sh_v;
    sat_res_t                res;
    one_v = {{(SUM_W-1){1'b0}}, 1'b1};
    max_v = (one_v <<< (dw - 1)) - one_v;
    min_v = ~max_v;
    sh_v  = sum >>> frac;
    if (sh_v > max_v) begin
      res.val = max_v[MAX_DW-1:0];
      res.sat = 1'b1;
    end else if (sh_v < min_v) begin
      res.val = min_v[MAX_DW-1:0];
      res.sat = 1'b1;
    end else begin
      res.val = sh_v[MAX_DW-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/park_transform_engine_if.sv
// Request/result bundle of the Park transform engine.
// PARK_SAT_FLAG_EN adds the sat_out saturation flags.
interface park_transform_engine_if #(parameter int DATA_WIDTH = 16);
  logic                         start_in;
  logic                         mode_in;
  logic signed [DATA_WIDTH-1:0] a_in;
  logic signed [DATA_WIDTH-1:0] b_in;
  logic signed [DATA_WIDTH-1:0] sin_in;
  logic signed [DATA_WIDTH-1:0] cos_in;
  logic                         ready_out;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic signed [DATA_WIDTH-1:0] y_out;
`ifdef PARK_SAT_FLAG_EN
  logic [1:0]                   sat_out;

  modport master (output start_in, mode_in, a_in, b_in, sin_in, cos_in,
                  input  ready_out, valid_out, x_out, y_out, sat_out);
  modport slave  (input  start_in, mode_in, a_in, b_in, sin_in, cos_in,
                  output ready_out, valid_out, x_out, y_out, sat_out);
`else
  modport master (output start_in, mode_in, a_in, b_in, sin_in, cos_in,
                  input  ready_out, valid_out, x_out, y_out);
  modport slave  (input  start_in, mode_in, a_in, b_in, sin_in, cos_in,
                  output ready_out, valid_out, x_out, y_out);
`endif
endinterface

// File: rtl/park_transform_engine_mult_pipe.sv
// Signed multiplier with MULT_LAT output register stages; behavioural stand-in
// for the vendor multiplier core.
module park_mult_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int MULT_LAT   = 1
) (
  input  logic                           clk_i,
  input  logic                           clr_i,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  output logic signed [2*DATA_WIDTH-1:0] p_o
);

  logic signed [2*DATA_WIDTH-1:0] stage_q [MULT_LAT];

  // Product pipeline, cleared synchronously.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < MULT_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
      for (int i = 1; i < MULT_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign p_o = stage_q[MULT_LAT-1];

endmodule

// File: rtl/park_transform_engine.sv
// Bidirectional Park transform: one shared multiplier over four products.
// Define PARK_SAT_FLAG_EN to expose per-result saturation flags on sat_out.
module park_transform_engine
  import park_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TRIG_FRAC  = 14,
  parameter int MULT_LAT   = 1
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  park_transform_engine_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [2:0] T_P0   = 3'(MULT_LAT);
  localparam logic [2:0] T_X    = 3'(MULT_LAT + 1);
  localparam logic [2:0] T_P2   = 3'(MULT_LAT + 2);
  localparam logic [2:0] T_LAST = 3'(MULT_LAT + 3);

  if (MULT_LAT < 1 || MULT_LAT > 4) begin : g_bad_lat
    $error("park_transform_engine: MULT_LAT must be within 1..4");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_bad_dw
    $error("park_transform_engine: DATA_WIDTH exceeds MAX_DW");
  end

  park_state_e                 state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic                        ready_s, accept_s;
  logic                        mode_q;
  logic signed [DATA_WIDTH-1:0] a_q, b_q, sin_q, cos_q;
  logic signed [DATA_WIDTH-1:0] mul_a_s, mul_b_s;
  logic signed [PW-1:0]        prod_s, p0_q, p2_q;
  logic signed [PW:0]          x_sum_s, y_sum_s;
  sat_res_t                    x_sat_s, y_sat_s;
  logic signed [DATA_WIDTH-1:0] x_hold_q, x_out_q, y_out_q;
  logic                        x_flag_q;
  logic [1:0]                  sat_q;

  assign accept_s = bus.start_in & ready_s;

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt runs 0..3 through ISSUE and continues through DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ST_ISSUE;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) state_d = ST_DRAIN;
        else               state_d = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (cnt_q == T_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output decode: handshake and multiplier operand selection.
  always_comb begin
    ready_s = 1'b0;
    mul_a_s = '0;
    mul_b_s = '0;
    case (state_q)
      ST_IDLE, ST_DONE: ready_s = 1'b1;
      ST_ISSUE: begin
        case (cnt_q[1:0])
          2'd0:    begin mul_a_s = a_q; mul_b_s = cos_q; end
          2'd1:    begin mul_a_s = b_q; mul_b_s = sin_q; end
          2'd2:    begin mul_a_s = a_q; mul_b_s = sin_q; end
          default: begin mul_a_s = b_q; mul_b_s = cos_q; end
        endcase
      end
      default: ready_s = 1'b0;
    endcase
  end

  park_mult_pipe #(.DATA_WIDTH(DATA_WIDTH), .MULT_LAT(MULT_LAT)) u_mult (
    .clk_i (sys_clk),
    .clr_i (~reset_n),
    .a_i   (mul_a_s),
    .b_i   (mul_b_s),
    .p_o   (prod_s)
  );

  // Pair accumulation: the second term's sign comes from the add/subtract, so no operand is negated.
  always_comb begin
    if (mode_q == MODE_INV_PARK) begin
      x_sum_s = $signed({p0_q[PW-1], p0_q}) - $signed({prod_s[PW-1], prod_s});
      y_sum_s = $signed({p2_q[PW-1], p2_q}) + $signed({prod_s[PW-1], prod_s});
    end else begin
      x_sum_s = $signed({p0_q[PW-1], p0_q}) + $signed({prod_s[PW-1], prod_s});
      y_sum_s = $signed({prod_s[PW-1], prod_s}) - $signed({p2_q[PW-1], p2_q});
    end
    x_sat_s = sat_shift(SUM_W'(x_sum_s), TRIG_FRAC, DATA_WIDTH);
    y_sat_s = sat_shift(SUM_W'(y_sum_s), TRIG_FRAC, DATA_WIDTH);
  end

  // Operand latch, product capture and result registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_INV_PARK;
      a_q      <= '0;
      b_q      <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
      p0_q     <= '0;
      p2_q     <= '0;
      x_hold_q <= '0;
      x_flag_q <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      sat_q    <= 2'b00;
    end else begin
      if (accept_s) begin
        mode_q <= bus.mode_in;
        a_q    <= bus.a_in;
        b_q    <= bus.b_in;
        sin_q  <= bus.sin_in;
        cos_q  <= bus.cos_in;
      end
      if (state_q == ST_ISSUE || state_q == ST_DRAIN) begin
        if (cnt_q == T_P0) p0_q <= prod_s;
        if (cnt_q == T_X) begin
          x_hold_q <= DATA_WIDTH'(x_sat_s.val);
          x_flag_q <= x_sat_s.sat;
        end
        if (cnt_q == T_P2) p2_q <= prod_s;
        if (cnt_q == T_LAST) begin
          x_out_q <= x_hold_q;
          y_out_q <= DATA_WIDTH'(y_sat_s.val);
          sat_q   <= {y_sat_s.sat, x_flag_q};
        end
      end
    end
  end

  assign bus.ready_out = ready_s;
  assign bus.valid_out = (state_q == ST_DONE);
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
`ifdef PARK_SAT_FLAG_EN
  assign bus.sat_out   = sat_q;
`else
  logic unused_sat_s;
  assign unused_sat_s = ^sat_q;
`endif

endmodule
